// File: rtl/dbg_addr_match.sv
// Debug-address match unit: NCH programmable comparators, a two-stage valid/ready
// lookup pipeline returning the lowest matching channel (+1), and saturating hit counters.
module dbg_addr_match #(
  parameter int NCH = 4,
  parameter int AW  = 32,
  parameter int CW  = 16,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic          cfg_en,
  input  logic [AW-1:0] cfg_addr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_val,
  output logic          rsp_hit,
  input  logic [IW-1:0] cnt_idx,
  output logic [CW-1:0] cnt_rd,
  input  logic          cnt_clr
);

  logic          en_tab   [NCH];
  logic [AW-1:0] addr_tab [NCH];
  logic [CW-1:0] cnt      [NCH];

  logic [NCH-1:0] m;
  logic [NCH-1:0] s1_m;
  logic           s1_valid;
  logic           s1_adv;
  logic           s2_adv;
  logic [31:0]    enc;
  logic           rsp_fire;

  assign s2_adv    = !rsp_valid || rsp_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign req_ready = s1_adv;
  assign rsp_fire  = rsp_valid && rsp_ready && rsp_hit;

  // Out-of-range cfg_idx matches no channel, so such writes fall through harmlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        en_tab[i]   <= 1'b0;
        addr_tab[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && cfg_idx == IW'(i)) begin
          en_tab[i]   <= cfg_en;
          addr_tab[i] <= cfg_addr;
        end
      end
    end
  end

  always_comb begin
    m = '0;
    for (int i = 0; i < NCH; i++) begin
      m[i] = en_tab[i] && (req_addr == addr_tab[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
    end else if (s1_adv) begin
      s1_valid <= req_valid;
      s1_m     <= m;
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    enc = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (s1_m[i]) enc = 32'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_val   <= '0;
      rsp_hit   <= 1'b0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_val <= enc;
        rsp_hit <= (enc != '0);
      end
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr) begin
          cnt[i] <= '0;
        end else if (rsp_fire && rsp_val == 32'(i + 1) && cnt[i] != '1) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_idx == IW'(i)) cnt_rd = cnt[i];
    end
  end

endmodule

// File: tb/tb_dbg_addr_match.sv
// Scoreboard bench for dbg_addr_match: directed lookups push expected responses,
// a negedge monitor pops and compares them, checks latency and stall stability.
module tb_dbg_addr_match;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int CW  = 2;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic          cfg_en;
  logic [AW-1:0] cfg_addr;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_val;
  logic          rsp_hit;
  logic [IW-1:0] cnt_idx;
  logic [CW-1:0] cnt_rd;
  logic          cnt_clr;

  typedef struct {
    logic [31:0] val;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          stalled  = 1'b0;
  logic [31:0] held_val = '0;

  dbg_addr_match #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_addr(cfg_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_val(rsp_val), .rsp_hit(rsp_hit),
    .cnt_idx(cnt_idx), .cnt_rd(cnt_rd), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per handshake and verifies outputs hold while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
        checkOutput("stall_val", rsp_val, held_val);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_val", rsp_val, e.val);
          checkOutput("rsp_hit", 32'(rsp_hit), 32'(e.val != 0));
          if (e.exp_cyc >= 0) checkOutput("rsp_latency", 32'(cyc), 32'(e.exp_cyc));
        end
      end
      stalled  = rsp_valid && !rsp_ready;
      held_val = rsp_val;
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [31:0] exp,
                               input bit lat, input bit push);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        if (push) sb.push_back('{val: exp, exp_cyc: lat ? cyc + 2 : -1});
      end
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleReq();
    req_valid = 1'b0;
  endtask

  task automatic cfgWrite(input int idx, input logic e, input logic [AW-1:0] a);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(idx);
    cfg_en   = e;
    cfg_addr = a;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic readCnt(input int idx, input logic [31:0] exp);
    cnt_idx = IW'(idx);
    #1;
    checkOutput($sformatf("cnt_rd[%0d]", idx), 32'(cnt_rd), exp);
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_addr = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; cnt_idx = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_val", rsp_val, 32'd0);
    checkOutput("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    readCnt(0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic back-to-back lookups");
    cfgWrite(0, 1'b1, 32'd1);
    cfgWrite(1, 1'b1, 32'd2);
    applyStimulus(32'd1, 32'd1, 1'b1, 1'b1);
    applyStimulus(32'd2, 32'd2, 1'b1, 1'b1);
    applyStimulus(32'd3, 32'd0, 1'b1, 1'b1);
    idleReq();
    waitDrain();
    readCnt(0, 1);
    readCnt(1, 1);

    $display("[TB] duplicate addresses and disabled channel");
    cfgWrite(0, 1'b1, 32'd5);
    cfgWrite(2, 1'b1, 32'd5);
    cfgWrite(1, 1'b0, 32'd5);
    applyStimulus(32'd5, 32'd1, 1'b1, 1'b1);
    idleReq();
    waitDrain();
    readCnt(0, 2);
    readCnt(1, 1);
    readCnt(2, 0);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(32'd5, 32'd1, 1'b0, 1'b1);
    applyStimulus(32'd9, 32'd0, 1'b0, 1'b1);
    req_valid = 1'b1;
    req_addr  = 32'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    applyStimulus(32'd5, 32'd1, 1'b0, 1'b1);
    idleReq();
    waitDrain();
    readCnt(0, 3);

    $display("[TB] same-cycle table write and lookup");
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_en = 1'b1; cfg_addr = 32'd7;
    applyStimulus(32'd7, 32'd0, 1'b1, 1'b1);
    cfg_we = 1'b0;
    applyStimulus(32'd7, 32'd4, 1'b1, 1'b1);
    idleReq();
    waitDrain();
    readCnt(3, 1);

    $display("[TB] saturation and clear");
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    readCnt(0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(32'd5, 32'd1, 1'b1, 1'b1);
    idleReq();
    waitDrain();
    readCnt(0, 3);
    readCnt(3, 0);
    rsp_ready = 1'b0;
    applyStimulus(32'd5, 32'd1, 1'b0, 1'b1);
    idleReq();
    @(posedge clk);
    #1;
    checkOutput("clr_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    readCnt(0, 0);
    waitDrain();

    $display("[TB] reset with full pipeline");
    rsp_ready = 1'b0;
    applyStimulus(32'd5, 32'd1, 1'b0, 1'b0);
    applyStimulus(32'd7, 32'd4, 1'b0, 1'b0);
    idleReq();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    readCnt(0, 0);
    applyStimulus(32'd5, 32'd0, 1'b1, 1'b1);
    applyStimulus(32'd7, 32'd0, 1'b1, 1'b1);
    applyStimulus(32'd0, 32'd0, 1'b1, 1'b1);
    idleReq();
    waitDrain();
    readCnt(0, 0);
    readCnt(3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
